// File: rtl/cache_pkg.sv
// Constants and types shared by the L2, the arbiter and the line/burst adapter.
package cache_pkg;

    localparam int S_OFFSET = 5;
    localparam int S_LINE   = 256;
    localparam int S_BEAT   = 64;
    localparam int BEATS    = S_LINE / S_BEAT;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} burst_state_t;

endpackage

// File: rtl/line_burst_adapter_if.sv
// Bus bundles for the adapter: the whole-line side facing the L2 and the
// beat-wide physical memory side.
interface line_bus_if;
    import cache_pkg::*;

    logic              line_read;
    logic              line_write;
    logic [31:0]       line_address;
    logic [S_LINE-1:0] line_wdata;
    logic              line_resp;
    logic [S_LINE-1:0] line_rdata;

    modport master (output line_read, line_write, line_address, line_wdata,
                    input  line_resp, line_rdata);
    modport slave  (input  line_read, line_write, line_address, line_wdata,
                    output line_resp, line_rdata);
endinterface

interface pmem_bus_if;
    import cache_pkg::*;

    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [S_BEAT-1:0] pmem_wdata;
    logic [S_BEAT-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (output pmem_read, pmem_write, pmem_address, pmem_wdata,
                    input  pmem_rdata, pmem_resp);
    modport slave  (input  pmem_read, pmem_write, pmem_address, pmem_wdata,
                    output pmem_rdata, pmem_resp);
endinterface

// File: rtl/line_beat_buffer.sv
// One cache line of storage: loaded whole from the L2 side, or filled one beat
// at a time from memory, with a beat-select read mux for outgoing write beats.
module line_beat_buffer
    import cache_pkg::*;
#(
    parameter int LINE_W = S_LINE,
    parameter int BEAT_W = S_BEAT,
    parameter int IDX_W  = CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [LINE_W-1:0] load_data,
    input  logic              beat_we,
    input  logic [IDX_W-1:0]  beat_idx,
    input  logic [BEAT_W-1:0] beat_wdata,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [LINE_W-1:0] line_q,
    output logic [BEAT_W-1:0] beat_q
);

    // A whole-line load and a beat write never coincide; the load wins if they did.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else if (load_en) begin
            line_q <= load_data;
        end else if (beat_we) begin
            line_q[beat_idx*BEAT_W +: BEAT_W] <= beat_wdata;
        end
    end

    assign beat_q = line_q[rd_idx*BEAT_W +: BEAT_W];

endmodule

// File: rtl/line_burst_adapter.sv
// Turns whole-line L2 fills/writebacks into ascending multi-beat memory bursts.
// Optional PMEM_PERF_EN adds saturating fill/writeback/busy-cycle counters.
module line_burst_adapter
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    line_bus_if.slave   line,
    pmem_bus_if.master  pmem,
    output logic [31:0] perf_reads,
    output logic [31:0] perf_writes,
    output logic [31:0] perf_busy
);

    localparam logic [31:0]      LINE_MASK = ~32'((1 << S_OFFSET) - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    burst_state_t      state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       addr_q;
    logic              rd_q;
    logic              wr_q;
    logic              resp_q;
    logic              accept_wr;
    logic              beat_we;
    logic              in_burst;
    logic              beat_done;
    logic [S_LINE-1:0] line_q;
    logic [S_BEAT-1:0] beat_q;

    assign in_burst  = (state == READ) || (state == WRITE);
    assign accept_wr = (state == IDLE) && !line.line_read && line.line_write;
    assign beat_we   = (state == READ) && pmem.pmem_resp;
    assign beat_done = in_burst && pmem.pmem_resp && (cnt == LAST_BEAT);

    line_beat_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .load_en    (accept_wr),
        .load_data  (line.line_wdata),
        .beat_we    (beat_we),
        .beat_idx   (cnt),
        .beat_wdata (pmem.pmem_rdata),
        .rd_idx     (cnt),
        .line_q     (line_q),
        .beat_q     (beat_q)
    );

    // Address register doubles as the bus address, so it is zeroed on leaving a burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            resp_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_q <= 1'b0;
                    if (line.line_read) begin
                        state  <= READ;
                        rd_q   <= 1'b1;
                        addr_q <= line.line_address & LINE_MASK;
                        cnt    <= '0;
                    end else if (line.line_write) begin
                        state  <= WRITE;
                        wr_q   <= 1'b1;
                        addr_q <= line.line_address & LINE_MASK;
                        cnt    <= '0;
                    end
                end
                READ, WRITE: begin
                    if (pmem.pmem_resp) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (beat_done) begin
                        state  <= DONE;
                        rd_q   <= 1'b0;
                        wr_q   <= 1'b0;
                        addr_q <= '0;
                        resp_q <= 1'b1;
                    end
                end
                DONE: begin
                    resp_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pmem.pmem_read    = rd_q;
    assign pmem.pmem_write   = wr_q;
    assign pmem.pmem_address = addr_q;
    assign pmem.pmem_wdata   = beat_q;
    assign line.line_resp    = resp_q;
    assign line.line_rdata   = line_q;

`ifdef PMEM_PERF_EN
    logic [31:0] reads_q;
    logic [31:0] writes_q;
    logic [31:0] busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reads_q  <= '0;
            writes_q <= '0;
            busy_q   <= '0;
        end else begin
            if (beat_done && (state == READ) && (reads_q != '1)) begin
                reads_q <= reads_q + 32'd1;
            end
            if (beat_done && (state == WRITE) && (writes_q != '1)) begin
                writes_q <= writes_q + 32'd1;
            end
            if (in_burst && (busy_q != '1)) begin
                busy_q <= busy_q + 32'd1;
            end
        end
    end

    assign perf_reads  = reads_q;
    assign perf_writes = writes_q;
    assign perf_busy   = busy_q;
`else
    assign perf_reads  = '0;
    assign perf_writes = '0;
    assign perf_busy   = '0;
`endif

endmodule
